// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between execute and the divider.
//   master (execute): drives signed_div_i, opdata1_i, opdata2_i, start_i,
//                     annul_i; receives result_o {rem, quot}, ready_o.
//   slave  (divider): the mirror image.
interface div_unit_if;
    localparam int RegBus = 32;

    logic                   signed_div_i;
    logic [RegBus-1:0]      opdata1_i;
    logic [RegBus-1:0]      opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*RegBus-1:0]    result_o;
    logic                   ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active low
//   bus  : div_unit_if.slave -- operands, sign mode, start/annul in;
//          registered {remainder, quotient} and ready out.
// One quotient bit per clock, MSB first; result is ready 32 clocks after
// the request is accepted, or one clock after for a zero divisor.
module div_unit (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] rem;       // partial remainder
    logic [31:0] dvd;       // dividend bits shift out the top, quotient bits in the bottom
    logic [31:0] dsr;       // divisor magnitude
    logic        sgn;
    logic        sign1;
    logic        sign2;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;

    // 2^31 magnitude of 0x80000000 fits the unsigned register unchanged.
    assign mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
    assign mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;

    // rem < dsr always, so the 33-bit difference never wraps and bit 32 is
    // a reliable sign.
    assign trial   = {rem, dvd[31]} - {1'b0, dsr};
    assign q_bit   = ~trial[32];
    assign rem_nxt = q_bit ? trial[31:0] : {rem[30:0], dvd[31]};
    assign quo_nxt = {dvd[30:0], q_bit};

    // Quotient sign is sign1^sign2; remainder follows the dividend.
    assign quo_fix = (sgn && (sign1 ^ sign2)) ? -quo_nxt : quo_nxt;
    assign rem_fix = (sgn && sign1)           ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_FREE;
            cnt          <= '0;
            rem          <= '0;
            dvd          <= '0;
            dsr          <= '0;
            sgn          <= 1'b0;
            sign1        <= 1'b0;
            sign2        <= 1'b0;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    bus.result_o <= '0;
                    bus.ready_o  <= 1'b0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end else begin
                            state <= S_ON;
                            sgn   <= bus.signed_div_i;
                            sign1 <= bus.opdata1_i[31];
                            sign2 <= bus.opdata2_i[31];
                            dvd   <= mag1;
                            dsr   <= mag2;
                            cnt   <= '0;
                            rem   <= '0;
                        end
                    end
                end
                S_BYZERO: begin
                    state        <= S_END;
                    bus.result_o <= '0;
                    bus.ready_o  <= 1'b1;
                end
                S_ON: begin
                    if (bus.annul_i) begin
                        state        <= S_FREE;
                        bus.result_o <= '0;
                        bus.ready_o  <= 1'b0;
                    end else begin
                        rem <= rem_nxt;
                        dvd <= quo_nxt;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state        <= S_END;
                            bus.result_o <= {rem_fix, quo_fix};
                            bus.ready_o  <= 1'b1;
                        end
                    end
                end
                S_END: begin
                    // Execute holds start until it has taken the result.
                    if (!bus.start_i || bus.annul_i) begin
                        state        <= S_FREE;
                        bus.result_o <= '0;
                        bus.ready_o  <= 1'b0;
                    end
                end
                default: state <= S_FREE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if bus();
    div_unit dut (.clk(clk), .rst(rst), .bus(bus));

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        ready_q  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values, so the
    // 0x80000000 / -1 case cannot overflow the model.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Monitor: every rising ready consumes one expected result.
    always @(negedge clk) begin
        if (bus.ready_o === 1'b1 && ready_q !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_ready: result %h with no request outstanding", bus.result_o);
            end else begin
                check("result", bus.result_o, exp_q.pop_front());
            end
        end
        ready_q = bus.ready_o;
    end

    // abort_at >= 0: abort (annul or reset) sampled on edge E(abort_at+1).
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int abort_at, input bit use_rst,
                           input bit scramble);
        int n;
        int lat;
        lat = (b == 32'd0) ? 1 : 32;
        if (abort_at < 0) exp_q.push_back(exp);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        @(posedge clk);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) break;
            if (abort_at >= 0 && n == abort_at + 1) break;
            if (n >= 40) break;
            if (scramble) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = 1'($urandom % 2);
            end
            if (n == abort_at) begin
                if (use_rst) rst = 1'b0;
                else         bus.annul_i = 1'b1;
            end
            @(posedge clk);
            n++;
        end
        if (abort_at >= 0) begin
            check("abort_ready", 64'(bus.ready_o), 64'd0);
            check("abort_result", bus.result_o, 64'd0);
            rst         = 1'b1;
            bus.annul_i = 1'b0;
            bus.start_i = 1'b0;
            repeat (40) @(negedge clk);
            check("abort_idle_ready", 64'(bus.ready_o), 64'd0);
        end else begin
            check("latency", 64'(n), 64'(lat));
            @(posedge clk);
            @(negedge clk);
            check("hold_ready", 64'(bus.ready_o), 64'd1);
            check("hold_result", bus.result_o, exp);
            bus.start_i   = 1'b0;
            bus.opdata1_i = $urandom;
            bus.opdata2_i = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("drop_ready", 64'(bus.ready_o), 64'd0);
            check("drop_result", bus.result_o, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        bit          s;
        rst              = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        rst = 1'b1;

        run_div(0, 32'd100, 32'd7, 64'h00000002_0000000E, -1, 0, 0);
        run_div(1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, -1, 0, 0);
        run_div(1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, -1, 0, 0);
        run_div(0, 32'd5, 32'd0, 64'd0, -1, 0, 1);
        run_div(0, 32'd123456, 32'd789, 64'd0, 9, 0, 0);
        run_div(0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, -1, 0, 0);
        run_div(1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, -1, 0, 0);
        run_div(0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, -1, 0, 0);
        run_div(1, 32'hFFFFFC18, 32'd3, 64'd0, 19, 1, 0);
        run_div(1, 32'hFFFF0000, 32'd13, ref_div(1, 32'hFFFF0000, 32'd13), -1, 0, 1);

        // start together with annul in FREE must not launch anything
        @(negedge clk);
        bus.opdata1_i = 32'd10;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        repeat (40) @(negedge clk);
        check("annul_start_free", 64'(bus.ready_o), 64'd0);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom % 2);
            a = $urandom;
            case ($urandom % 5)
                0:       b = $urandom;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                3:       b = 32'd0;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_div(s, a, b, ref_div(s, a, b), -1, 0, 1'($urandom % 2));
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider with its own sequencing FSM, serving DIV/DIVU in the execute stage. Execute raises `start_i` with latched operands, stalls the pipeline while busy, and releases the request once `ready_o` returns the 64-bit {remainder, quotient} result bound for HI/LO. Restoring division produces one quotient bit per clock. A request can be annulled mid-operation on a flush.

## Interface
Parameters: none (data width fixed at 32 via `RegBus`).
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous reset, active-low; sampled on `clk` rising edge
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- `opdata1_i`  in  32  dividend
- `opdata2_i`  in  32  divisor
- `start_i`  in  1  request; held high by execute until it has consumed `ready_o`
- `annul_i`  in  1  cancel current/pending request (flush)
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}, registered
- `ready_o`  out  1  result valid, registered

## Operation
- States: FREE, BYZERO, ON, END. Reset state FREE.
- FREE:
  - `start_i`=1 and `annul_i`=0 and `opdata2_i`=0 -> BYZERO.
  - `start_i`=1 and `annul_i`=0 and divisor nonzero -> ON.
    - Latch `signed_div_i`, the operand sign bits, and magnitudes. If signed and operand negative, magnitude = two's complement; else raw value.
    - Clear iteration counter (6 bits) and 32-bit partial remainder.
  - Otherwise stay; outputs 0.
- ON: one iteration per clock, MSB first.
  - trial = {partial_rem[31:0], next dividend bit} − {1'b0, divisor_mag} (33-bit).
  - If trial ≥ 0: partial_rem ← trial[31:0], quotient bit = 1.
  - Else: partial_rem ← shifted value, quotient bit = 0.
  - Counter increments.
  - `annul_i`=1 in any ON cycle -> FREE immediately; no result, `ready_o` stays 0.
  - After the 32nd iteration -> END.
- Entering END:
  - Quotient negated if latched signed and sign1≠sign2.
  - Remainder negated if latched signed and sign1=1 (remainder takes dividend sign).
  - `result_o` loaded; `ready_o` ← 1.
- BYZERO: next edge -> END with `result_o`=0, `ready_o`=1.
- END:
  - Hold `result_o`/`ready_o` while `start_i`=1.
  - On an edge with `start_i`=0 or `annul_i`=1 -> FREE; `ready_o` ← 0, `result_o` ← 0.
- Boundary cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. Magnitude 2^31 is held in an unsigned 32-bit register; no trap.
  - Operand input changes after FREE->ON/BYZERO are ignored; latched copies are used.
  - `start_i` while in ON/BYZERO/END is not a new request.
  - `rst`=0 overrides all: next edge forces FREE, counter 0, `ready_o`=0, `result_o`=0, including mid-division.
  - Simultaneous `annul_i` and `start_i` in FREE: annul wins, stay FREE.

## Timing
- E0 = edge sampling `start_i`=1 in FREE.
- Nonzero divisor: iterations on E1..E32; `ready_o`=1 and `result_o` valid after E32. Latency 32 clocks from E0.
- Zero divisor: `ready_o`=1 after E1.
- `ready_o` falls on the first edge where `start_i`=0, then FREE. A new request is accepted no earlier than the following edge.
- Annul in ON: FREE after the same edge; no residual `ready_o` pulse.
- All outputs registered; no combinational input→output path.
- Reset values: `ready_o`=0, `result_o`=64'h0.

## Test plan
1. Unsigned 100 / 7, start held -> after E32, `ready_o`=1, `result_o`=64'h00000002_0000000E; drop start -> `ready_o`=0 and `result_o`=0 next edge.
2. Signed 0xFFFFFFF9 (−7) / 2 -> `result_o`=64'hFFFFFFFF_FFFFFFFD (rem −1, quot −3). Signed 7 / 0xFFFFFFFE -> 64'h00000001_FFFFFFFD.
3. Divide by zero: 5 / 0 -> `ready_o`=1 after E1, `result_o`=0; no ON cycles.
4. Annul during iteration 10 -> FREE next edge, `ready_o` never rises. Then unsigned 0xFFFFFFFF / 1 -> 64'h00000000_FFFFFFFF at E0+32.
5. Signed 0x80000000 / 0xFFFFFFFF -> 64'h00000000_80000000. Unsigned 0x80000000 / 0xFFFFFFFF -> 64'h80000000_00000000.
6. `rst`=0 at iteration 20 -> after that edge, state FREE, outputs 0. Operands changed mid-ON (no reset) -> result still matches latched operands.
